conv1d_seq: RTL
===============

# conv1d_seq

Time-multiplexed, parametrised successor of the flat 1-D convolution layer in the keyword-spotting front end. It buffers one MFCC frame (WIDTH positions × IN_CH channels), then computes NUM_FILTERS same-padded outputs per position on a single signed MAC. Each result is requantised by FRAC_BITS, optionally ReLU'd, and saturated. Results stream out one position per beat under valid/ready back-pressure, in place of the fully-unrolled combinational array.

## Interface
- WIDTH, 40: positions per frame.
- IN_CH, 1: input channels.
- NUM_FILTERS, 8: output channels.
- KERNEL, 3: taps; must be odd; PAD = (KERNEL-1)/2.
- DATA_W, 16: signed two's-complement width of data, weights and biases.
- FRAC_BITS, 8: fractional bits of weights (Q-format shift).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame start pulse; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  input sample valid.
- s_ready  out  1  high only in LOAD.
- s_data  in  IN_CH*DATA_W  one position; channel c at [c*DATA_W +: DATA_W].
- m_valid  out  1  output position valid.
- m_ready  in  1  downstream ready.
- m_data  out  NUM_FILTERS*DATA_W  filter f at [f*DATA_W +: DATA_W].
- m_last  out  1  high with the beat for position WIDTH-1.
- frame_done  out  1  one-cycle pulse after the final beat handshakes.
- w_wr_en  in  1  coefficient write strobe.
- w_addr  in  clog2(NUM_FILTERS*(IN_CH*KERNEL+1))  coefficient address.
- w_data  in  DATA_W  coefficient value.

## Operation
- Coefficient map: weight (f,c,k) at address (f*IN_CH+c)*KERNEL+k; tap k multiplies position p+k-PAD. Bias f is at NUM_FILTERS*IN_CH*KERNEL+f.
- Writes apply only in IDLE. Writes in other states, and writes to out-of-range addresses, are dropped silently.
- FSM: IDLE -> LOAD on start.
- LOAD: accepts exactly WIDTH beats (s_valid&s_ready), stored at positions 0..WIDTH-1 in arrival order. Moves to COMPUTE after the WIDTH-th beat.
- COMPUTE: for the current position p, processes filters f=0..NUM_FILTERS-1 in turn.
  - One init cycle: acc = sign-extended bias << FRAC_BITS.
  - Then IN_CH*KERNEL MAC cycles, channel-major, tap-minor: acc += w*x.
  - Taps falling outside [0, WIDTH-1] add zero.
- acc width: ACC_W = 2*DATA_W + clog2(IN_CH*KERNEL+1) + 1; no overflow is possible internally.
- Requantise: y = acc >>> FRAC_BITS (arithmetic, truncating toward -inf), then ReLU (see Configuration), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Write y into slot f of the output register.
- After the last filter, move to OUT. OUT holds m_valid and m_data until m_ready.
- On the OUT handshake:
  - p<WIDTH-1: p++ and return to COMPUTE.
  - Otherwise: pulse frame_done and return to IDLE.
- start outside IDLE is ignored. A write and start in the same IDLE cycle: both take effect, and the write is used by that frame.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0. FSM goes to IDLE and p=0. All weights, biases and the frame buffer are cleared to 0.
- Reset mid-frame aborts at once; there is no partial output afterwards.
- start sampled in IDLE: s_ready=1 and busy=1 on the next cycle.
- s_ready drops the cycle after the WIDTH-th accepted beat; COMPUTE begins that cycle.
- Per position: m_valid rises NUM_FILTERS*(IN_CH*KERNEL+1) cycles after COMPUTE entry.
- m_data and m_last are stable while m_valid=1 and m_ready=0.
- After the handshake, m_valid=0 on the next cycle; it never stays high across two positions.
- frame_done is high for exactly the cycle after the last handshake; busy=0 in that same cycle.

## Configuration
- CONV1D_SEQ_RELU_EN defined: negative y is forced to 0 before saturation, so outputs lie in [0, 2^(DATA_W-1)-1].
- Undefined: signed results pass through; only saturation applies.

## Test plan
Bench parameters: WIDTH=4, IN_CH=2, NUM_FILTERS=2, KERNEL=3, DATA_W=16, FRAC_BITS=8.
- Identity: w(0,0,1)=256, all other coefficients 0; ch0 input 10,20,30,40 -> filter0 gives 10,20,30,40 and filter1 gives 0. m_last on beat 4, frame_done one cycle later.
- Padding: w(0,0,0..2)=256; ch0 input 1,1,1,1 -> filter0 gives 2,3,3,2.
- Saturation and bias: all weights 0x7FFF, bias 0x7FFF, all inputs 0x7FFF -> 0x7FFF. All weights 0x8000, inputs 0x7FFF, macro off -> 0x8000.
- ReLU: w(0,0,1)=-256, input 5 -> 0 with CONV1D_SEQ_RELU_EN, 0xFFFB without.
- Back-pressure and timing:
  - Hold m_ready=0 for 10 cycles on each beat -> m_data unchanged while held, exactly 4 beats, no skipped positions.
  - First m_valid 14 cycles after COMPUTE entry.
  - Writes and start issued while busy have no effect.
- Reset: assert rst_n=0 mid-COMPUTE -> all outputs 0 and FSM in IDLE. A new frame then yields 0 everywhere, because the coefficients were cleared.

Source files
------------

// File: rtl/conv1d_seq_if.sv
// Stream bundle for conv1d_seq: one frame position in, all filter outputs for one position out.
// The master side is the producer/consumer environment; the slave side is the convolution engine.
interface conv1d_seq_if #(
  parameter int IN_CH       = 1,
  parameter int NUM_FILTERS = 8,
  parameter int DATA_W      = 16
);
   logic                          s_valid;
   logic                          s_ready;
   logic [IN_CH*DATA_W-1:0]       s_data;
   logic                          m_valid;
   logic                          m_ready;
   logic [NUM_FILTERS*DATA_W-1:0] m_data;
   logic                          m_last;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/conv1d_seq.sv
// Time-multiplexed same-padded 1-D convolution: buffer a frame, one signed MAC, stream one position per beat.
// Optional macro CONV1D_SEQ_RELU_EN clamps negative results to zero before saturation.
module conv1d_seq #(
  parameter int WIDTH       = 40,
  parameter int IN_CH       = 1,
  parameter int NUM_FILTERS = 8,
  parameter int KERNEL      = 3,
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  parameter int W_AW        = $clog2(NUM_FILTERS*(IN_CH*KERNEL+1))
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     frame_done,
   input  logic                     w_wr_en,
   input  logic [W_AW-1:0]          w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   conv1d_seq_if.slave              strm
);
   localparam int PAD   = (KERNEL-1)/2;
   localparam int TAPS  = IN_CH*KERNEL;
   localparam int NW    = NUM_FILTERS*TAPS;
   localparam int NCOEF = NUM_FILTERS*(TAPS+1);
   localparam int ACC_W = 2*DATA_W + $clog2(TAPS+1) + 1;
   localparam int PW    = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
   localparam int CW    = (IN_CH > 1)       ? $clog2(IN_CH)       : 1;
   localparam int KW    = (KERNEL > 1)      ? $clog2(KERNEL)      : 1;
   localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

   localparam logic [W_AW:0] NCOEF_L = (W_AW+1)'(NCOEF);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     load_cnt_q;
   logic [PW-1:0]     pos_q;
   logic [FW-1:0]     filt_q;
   logic [CW-1:0]     ch_q;
   logic [KW-1:0]     tap_q;
   logic              init_q;
   logic              last_mac;
   logic              fin;

   logic signed [DATA_W-1:0]   coef_q  [NCOEF];
   logic signed [DATA_W-1:0]   frame_q [WIDTH][IN_CH];
   logic signed [ACC_W-1:0]    acc_p0;
   logic [NUM_FILTERS*DATA_W-1:0] out_p1;

   int                         pos_i;
   logic [PW-1:0]              pidx;
   logic signed [DATA_W-1:0]   x_sel, w_sel, b_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_nxt, bias_ext;

   // Arithmetic shift floors toward -inf; the optional clamp runs before saturation.
   function automatic logic signed [ACC_W-1:0] requant(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] y;
      y = a >>> FRAC_BITS;
`ifdef CONV1D_SEQ_RELU_EN
      if (y[ACC_W-1]) y = '0;
`endif
      return y;
   endfunction

   function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (a < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return a[DATA_W-1:0];
   endfunction

   always_comb begin
      state_d       = state_q;
      fin           = 1'b0;
      last_mac      = !init_q && (tap_q == KW'(KERNEL-1)) && (ch_q == CW'(IN_CH-1));
      busy          = (state_q != IDLE);
      strm.s_ready  = (state_q == LOAD);
      strm.m_valid  = (state_q == OUT);
      strm.m_last   = (state_q == OUT) && (pos_q == PW'(WIDTH-1));
      unique case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (strm.s_valid && load_cnt_q == PW'(WIDTH-1)) state_d = COMPUTE;
         COMPUTE: if (last_mac && filt_q == FW'(NUM_FILTERS-1)) state_d = OUT;
         OUT:
            if (strm.m_ready) begin
               if (pos_q == PW'(WIDTH-1)) begin
                  state_d = IDLE;
                  fin     = 1'b1;
               end else begin
                  state_d = COMPUTE;
               end
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         load_cnt_q <= '0;
         pos_q      <= '0;
         filt_q     <= '0;
         ch_q       <= '0;
         tap_q      <= '0;
         init_q     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_done <= fin;
         if (state_q == IDLE) begin
            load_cnt_q <= '0;
            pos_q      <= '0;
         end
         if (state_q == LOAD && strm.s_valid) load_cnt_q <= load_cnt_q + PW'(1);
         if (state_q == OUT && strm.m_ready && pos_q != PW'(WIDTH-1)) pos_q <= pos_q + PW'(1);
         // Channel-major, tap-minor walk; each filter starts with one bias-load cycle.
         if (state_q != COMPUTE) begin
            filt_q <= '0;
            ch_q   <= '0;
            tap_q  <= '0;
            init_q <= 1'b1;
         end else if (init_q) begin
            init_q <= 1'b0;
         end else if (tap_q == KW'(KERNEL-1)) begin
            tap_q <= '0;
            if (ch_q == CW'(IN_CH-1)) begin
               ch_q   <= '0;
               init_q <= 1'b1;
               filt_q <= (filt_q == FW'(NUM_FILTERS-1)) ? '0 : filt_q + FW'(1);
            end else begin
               ch_q <= ch_q + CW'(1);
            end
         end else begin
            tap_q <= tap_q + KW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
         for (int p = 0; p < WIDTH; p++)
            for (int c = 0; c < IN_CH; c++) frame_q[p][c] <= '0;
      end else begin
         if (state_q == IDLE && w_wr_en && ({1'b0, w_addr} < NCOEF_L)) coef_q[w_addr] <= w_data;
         if (state_q == LOAD && strm.s_valid)
            for (int c = 0; c < IN_CH; c++)
               frame_q[load_cnt_q][c] <= strm.s_data[c*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      pos_i    = int'(pos_q) + int'(tap_q) - PAD;
      pidx     = PW'(pos_i);
      x_sel    = '0;
      if (pos_i >= 0 && pos_i < WIDTH) x_sel = frame_q[pidx][ch_q];
      w_sel    = coef_q[W_AW'((int'(filt_q)*IN_CH + int'(ch_q))*KERNEL + int'(tap_q))];
      b_sel    = coef_q[W_AW'(NW + int'(filt_q))];
      prod     = (2*DATA_W)'(x_sel) * (2*DATA_W)'(w_sel);
      acc_nxt  = acc_p0 + ACC_W'(prod);
      bias_ext = ACC_W'(b_sel) <<< FRAC_BITS;
   end

   // Stage p0: accumulator; stage p1: requantised per-filter output slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p0 <= '0;
         out_p1 <= '0;
      end else if (state_q == COMPUTE) begin
         acc_p0 <= init_q ? bias_ext : acc_nxt;
         if (last_mac) out_p1[int'(filt_q)*DATA_W +: DATA_W] <= saturate(requant(acc_nxt));
      end
   end

   assign strm.m_data = out_p1;

endmodule
